// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps the PC, issues one request at a time to
// instruction memory and holds the returned word in a one-entry decode buffer.
// A branch redirect flushes the buffer. If a granted request is still in
// flight when the redirect arrives, its response is tracked and discarded.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        take_branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // free to issue a request
    ST_WAIT = 2'd1,  // one granted request outstanding, response wanted
    ST_DROP = 2'd2   // one granted request outstanding, response stale
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;  // address of the outstanding request
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic        transfer;
  logic        granted;
  logic        fill;
  logic [31:0] branch_pc;

  assign transfer  = valid_q & instr_ready_i;
  assign granted   = imem_req_o & imem_gnt_i;
  // A response only lands in the buffer if it is wanted and not overtaken by a redirect.
  assign fill      = (state_q == ST_WAIT) & imem_rvalid_i & ~take_branch_i;
  // Masking keeps the full target in use while forcing word alignment.
  assign branch_pc = branch_target_i & 32'hFFFF_FFFC;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, no matter in which order the blocks execute.
    if (!rstn_i) state_q <= ST_REQ;
    else         state_q <= state_d;
  end

  // FSM next-state logic; a redirect decides whether the in-flight response is stale.
  always_comb begin
    // NOTE: default first so that every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_REQ: begin
        if (granted) state_d = take_branch_i ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid_i)      state_d = ST_REQ;
        else if (take_branch_i) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid_i) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // FSM outputs: request while the buffer is empty or being emptied, never during reset.
  always_comb begin
    imem_req_o  = rstn_i & (state_q == ST_REQ) & (~valid_q | instr_ready_i);
    imem_addr_o = pc_q;
  end

  // Next values for the PC, the outstanding address and the decode buffer.
  // A redirect has priority over increment, fill and transfer.
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    if (take_branch_i)  pc_d = branch_pc;
    else if (granted)   pc_d = pc_q + 32'd4;

    if (granted) req_addr_d = pc_q;

    if (take_branch_i) begin
      valid_d = 1'b0;
    end else if (fill) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata_i;
      instr_pc_d = req_addr_q;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pc_q       <= RESET_PC;
      req_addr_q <= 32'd0;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rstn_i  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk_i.
REQ-004 take_branch_i  input  1  SHALL be the redirect request from the branch compare stage, one-cycle pulse.
REQ-005 branch_target_i  input  32  SHALL be the redirect address, valid when take_branch_i=1.
REQ-006 imem_req_o  output  1  SHALL be the instruction memory request.
REQ-007 imem_addr_o  output  32  SHALL be the request address, word-aligned.
REQ-008 imem_gnt_i  input  1  SHALL be the request acceptance, same cycle as imem_req_o.
REQ-009 imem_rvalid_i  input  1  SHALL be the response strobe, earliest one cycle after grant.
REQ-010 imem_rdata_i  input  32  SHALL be the response instruction word.
REQ-011 instr_valid_o  output  1  SHALL be high while an instruction is held for decode.
REQ-012 instr_o  output  32  SHALL be the held instruction.
REQ-013 instr_pc_o  output  32  SHALL be the address of instr_o.
REQ-014 instr_ready_i  input  1  SHALL be decode acceptance; transfer occurs when instr_valid_o & instr_ready_i.

Function
REQ-015 Block SHALL hold a 32-bit PC register and a one-entry output buffer (instr_o, instr_pc_o, instr_valid_o).
REQ-016 FSM SHALL have states REQ (may issue), WAIT (one granted request outstanding), DROP (one granted, flushed request outstanding).
REQ-017 At most one granted request SHALL be outstanding.
REQ-018 In REQ, imem_req_o SHALL be 1 iff buffer empty or a transfer occurs this cycle; imem_addr_o = PC.
REQ-019 REQ->WAIT on imem_req_o & imem_gnt_i; PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 While imem_req_o=1 and no grant and no redirect, imem_req_o and imem_addr_o SHALL stay stable.
REQ-021 WAIT->REQ on imem_rvalid_i; buffer <= {1, imem_rdata_i, granted address} in the same edge.
REQ-022 Transfer with no fill SHALL clear instr_valid_o next cycle; instr_o/instr_pc_o retain old values.
REQ-023 Buffer SHALL hold its contents unchanged while instr_valid_o=1 and instr_ready_i=0.
REQ-024 On take_branch_i=1, PC <= {branch_target_i[31:2], 2'b00} and instr_valid_o <= 0, any state.
REQ-025 Redirect in REQ with grant same cycle SHALL go to DROP (granted address is stale); without grant, stay REQ, the ungranted request being withdrawn.
REQ-026 Redirect in WAIT without rvalid SHALL go to DROP; with rvalid same cycle, response discarded, go REQ.
REQ-027 In DROP, imem_req_o=0; on imem_rvalid_i the response SHALL be discarded and FSM goes REQ.
REQ-028 Redirect in DROP SHALL update PC only and remain in DROP.
REQ-029 Redirect SHALL take priority over fill, transfer, and PC increment in the same cycle.
REQ-030 First request after a redirect SHALL use the redirected address.

Reset
REQ-031 While rstn_i=0 at a rising edge: PC <= RESET_PC, FSM <= REQ, instr_valid_o <= 0, instr_o <= 0, instr_pc_o <= 0.
REQ-032 imem_req_o SHALL be 0 while rstn_i=0; a response arriving during reset SHALL be ignored.
REQ-033 Reset mid-transaction SHALL abandon outstanding requests; no DROP tracking is kept across reset.

Verification
REQ-034 Reset release, gnt=1 always, rvalid 1 cycle later, ready=1 -> addresses 0,4,8 issued; instr_pc_o 0,4,8 in order.
REQ-035 ready=0 with buffer full holding PC 0x4 -> imem_req_o=0; outputs stable; ready=1 -> transfer, next request 0x8.
REQ-036 take_branch_i=1, target 0x103, in WAIT -> next rvalid discarded; next request address 0x100; first valid instr_pc_o=0x100.
REQ-037 take_branch_i=1 coincident with rvalid -> rvalid data never appears; instr_valid_o=0 next cycle; request to target next.
REQ-038 PC=0xFFFF_FFFC granted -> next request address 0x0000_0000.
REQ-039 rstn_i=0 while in WAIT -> outputs zero next cycle; after release first request is RESET_PC.
